// File: rtl/rcn_pkg.sv
// Shared rcn bus field widths and tag-slot helpers used by the master-side arbiter.
package rcn_pkg;

    localparam int RCN_ID_W     = 6;
    localparam int RCN_SEQ_W    = 2;
    localparam int RCN_MASK_W   = 4;
    localparam int RCN_ADDR_W   = 20;
    localparam int RCN_BADDR_W  = RCN_ADDR_W + 2;
    localparam int RCN_DATA_W   = 32;
    localparam int RCN_NUM_TAGS = 4;
    localparam int RCN_OWNER_W  = 3;

    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,
        RSP_HIT    = 2'd1,
        RSP_ORPHAN = 2'd2
    } rsp_kind_t;

    // Lowest-numbered clear bit; only meaningful when at least one tag is free.
    function automatic logic [RCN_SEQ_W-1:0] lowest_free(input logic [RCN_NUM_TAGS-1:0] valid);
        logic [RCN_SEQ_W-1:0] t;
        t = '0;
        for (int k = RCN_NUM_TAGS - 1; k >= 0; k--) begin
            if (!valid[k]) t = RCN_SEQ_W'(k);
        end
        return t;
    endfunction

endpackage

// File: rtl/rcn_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, searching cyclically.
module rcn_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                           = 1'b1;
                grant[(int'(ptr) + i) % N]    = 1'b1;
                grant_idx                     = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/rcn_master_arb.sv
// Shares one rcn_master among NUM_REQ requesters using the four seq tags as outstanding slots.
// Optional per-tag response timeout is built when RCN_MASTER_ARB_TIMEOUT_EN is defined.
module rcn_master_arb
    import rcn_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_cs,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [4*NUM_REQ-1:0]    req_mask,
    input  logic [22*NUM_REQ-1:0]   req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      rsp_rdone,
    output logic [NUM_REQ-1:0]      rsp_wdone,
    output logic [NUM_REQ-1:0]      rsp_timeout,
    output logic [3:0]              rsp_mask,
    output logic [21:0]             rsp_addr,
    output logic [31:0]             rsp_data,
    output logic                    orphan,
    output logic                    m_cs,
    output logic [1:0]              m_seq,
    output logic                    m_wr,
    output logic [3:0]              m_mask,
    output logic [21:0]             m_addr,
    output logic [31:0]             m_wdata,
    input  logic                    m_busy,
    input  logic                    m_rdone,
    input  logic                    m_wdone,
    input  logic [1:0]              m_rsp_seq,
    input  logic [3:0]              m_rsp_mask,
    input  logic [21:0]             m_rsp_addr,
    input  logic [31:0]             m_rsp_data
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a request transfers on any cycle with m_cs high and m_busy low; the
    // requester holds req_cs and its fields until the matching req_ack pulse.
    logic [RCN_NUM_TAGS-1:0] tag_valid;
    logic [RCN_NUM_TAGS-1:0] tag_wr;
    logic [RCN_OWNER_W-1:0]  tag_owner [RCN_NUM_TAGS];
    logic [REQ_W-1:0]        rr_ptr;

    logic [NUM_REQ-1:0]      grant;
    logic [REQ_W-1:0]        grant_idx;
    logic                    any_req;
    logic                    any_free;
    logic [RCN_SEQ_W-1:0]    alloc_tag;
    logic                    eligible;
    logic                    accept;
    rsp_kind_t               rsp_kind;
    logic [RCN_NUM_TAGS-1:0] tmo_fire;

    rcn_rr_pick #(
        .N (NUM_REQ),
        .W (REQ_W)
    ) u_pick (
        .req       (req_cs),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Free tags come from registered state only, so a tag freed this cycle is not reused yet.
    assign any_free  = ~&tag_valid;
    assign alloc_tag = lowest_free(tag_valid);
    assign eligible  = any_req && any_free && !rst;
    assign accept    = eligible && !m_busy;

    always_comb begin
        rsp_kind = RSP_NONE;
        if (!rst && (m_rdone || m_wdone)) begin
            rsp_kind = tag_valid[m_rsp_seq] ? RSP_HIT : RSP_ORPHAN;
        end
    end

`ifdef RCN_MASTER_ARB_TIMEOUT_EN
    localparam int AGE_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    logic [AGE_W-1:0] tag_age [RCN_NUM_TAGS];

    // A response in the same cycle as the timeout wins, so that tag does not time out.
    always_comb begin
        tmo_fire = '0;
        for (int k = 0; k < RCN_NUM_TAGS; k++) begin
            if (!rst && tag_valid[k] && tag_age[k] == AGE_W'(TIMEOUT) &&
                !(rsp_kind == RSP_HIT && m_rsp_seq == RCN_SEQ_W'(k))) begin
                tmo_fire[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RCN_NUM_TAGS; k++) tag_age[k] <= '0;
        end else begin
            for (int k = 0; k < RCN_NUM_TAGS; k++) begin
                if (accept && alloc_tag == RCN_SEQ_W'(k)) begin
                    tag_age[k] <= '0;
                end else if (tag_valid[k]) begin
                    tag_age[k] <= tag_age[k] + 1'b1;
                end
            end
        end
    end
`else
    assign tmo_fire = '0;
`endif

    always_comb begin
        req_ack     = '0;
        rsp_rdone   = '0;
        rsp_wdone   = '0;
        rsp_timeout = '0;
        if (accept) req_ack = grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_kind == RSP_HIT && tag_owner[m_rsp_seq] == RCN_OWNER_W'(i)) begin
                if (tag_wr[m_rsp_seq]) rsp_wdone[i] = 1'b1;
                else                   rsp_rdone[i] = 1'b1;
            end
            for (int k = 0; k < RCN_NUM_TAGS; k++) begin
                if (tmo_fire[k] && tag_owner[k] == RCN_OWNER_W'(i)) rsp_timeout[i] = 1'b1;
            end
        end
    end

    always_comb begin
        m_cs     = eligible;
        m_seq    = '0;
        m_wr     = 1'b0;
        m_mask   = '0;
        m_addr   = '0;
        m_wdata  = '0;
        orphan   = (rsp_kind == RSP_ORPHAN);
        rsp_mask = '0;
        rsp_addr = '0;
        rsp_data = '0;
        if (!rst) begin
            m_seq    = alloc_tag;
            m_wr     = req_wr[grant_idx];
            m_mask   = req_mask[int'(grant_idx) * 4 +: 4];
            m_addr   = req_addr[int'(grant_idx) * 22 +: 22];
            m_wdata  = req_wdata[int'(grant_idx) * 32 +: 32];
            rsp_mask = m_rsp_mask;
            rsp_addr = m_rsp_addr;
            rsp_data = m_rsp_data;
        end
    end

    // An allocating tag is never the completing one: allocation only picks invalid tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_wr    <= '0;
            rr_ptr    <= '0;
            for (int k = 0; k < RCN_NUM_TAGS; k++) tag_owner[k] <= '0;
        end else begin
            for (int k = 0; k < RCN_NUM_TAGS; k++) begin
                if (accept && alloc_tag == RCN_SEQ_W'(k)) begin
                    tag_valid[k] <= 1'b1;
                    tag_wr[k]    <= req_wr[grant_idx];
                    tag_owner[k] <= RCN_OWNER_W'(grant_idx);
                end else if ((rsp_kind == RSP_HIT && m_rsp_seq == RCN_SEQ_W'(k)) || tmo_fire[k]) begin
                    tag_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rcn_master_arb.sv
// Scoreboarded bench for rcn_master_arb: directed cycle tables push expected events, a monitor pops them.
module tb_rcn_master_arb;

    localparam int N = 4;
    localparam logic [3:0] K_ACK = 4'd1, K_RD = 4'd2, K_WD = 4'd3, K_ORPH = 4'd4, K_TMO = 4'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_cs, req_wr, req_ack, rsp_rdone, rsp_wdone, rsp_timeout;
    logic [4*N-1:0]  req_mask;
    logic [22*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [3:0]      rsp_mask, m_mask, m_rsp_mask;
    logic [21:0]     rsp_addr, m_addr, m_rsp_addr;
    logic [31:0]     rsp_data, m_wdata, m_rsp_data;
    logic            orphan, m_cs, m_wr, m_busy, m_rdone, m_wdone;
    logic [1:0]      m_seq, m_rsp_seq;

    logic [21:0] addr_tab [N];
    logic [3:0]  mask_tab [N];
    logic [31:0] wdat_tab [N];

    logic [47:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    rcn_master_arb #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_cs(req_cs), .req_wr(req_wr), .req_mask(req_mask), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack),
        .rsp_rdone(rsp_rdone), .rsp_wdone(rsp_wdone), .rsp_timeout(rsp_timeout),
        .rsp_mask(rsp_mask), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .orphan(orphan),
        .m_cs(m_cs), .m_seq(m_seq), .m_wr(m_wr), .m_mask(m_mask), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_busy(m_busy),
        .m_rdone(m_rdone), .m_wdone(m_wdone), .m_rsp_seq(m_rsp_seq),
        .m_rsp_mask(m_rsp_mask), .m_rsp_addr(m_rsp_addr), .m_rsp_data(m_rsp_data)
    );

    function automatic logic [47:0] mk(input logic [3:0] kind, input logic [7:0] vec,
                                       input logic [3:0] aux, input logic [31:0] data);
        return {kind, vec, aux, data};
    endfunction

    task automatic push_ack(input int r, input logic [1:0] seq, input logic wr);
        exp_q.push_back(mk(K_ACK, 8'(1 << r), {1'b0, wr, seq}, {10'b0, addr_tab[r]}));
    endtask

    task automatic push_evt(input logic [3:0] kind, input int owner, input logic [31:0] data);
        exp_q.push_back(mk(kind, (owner < 0) ? 8'h00 : 8'(1 << owner), 4'h0, data));
    endtask

    task automatic compare_evt(input string name, input logic [47:0] obs);
        logic [47:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event got=%h expected none", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                errors++;
                $display("FAIL %s: got=%h expected=%h", name, obs, e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per observed event, in a fixed per-cycle order.
    always @(negedge clk) begin
        if (req_ack != '0)     compare_evt("ack",     mk(K_ACK, 8'(req_ack), {1'b0, m_wr, m_seq}, {10'b0, m_addr}));
        if (rsp_rdone != '0)   compare_evt("rdone",   mk(K_RD, 8'(rsp_rdone), 4'h0, rsp_data));
        if (rsp_wdone != '0)   compare_evt("wdone",   mk(K_WD, 8'(rsp_wdone), 4'h0, rsp_data));
        if (orphan)            compare_evt("orphan",  mk(K_ORPH, 8'h00, 4'h0, rsp_data));
        if (rsp_timeout != '0) compare_evt("timeout", mk(K_TMO, 8'(rsp_timeout), 4'h0, 32'h0));
    end

    task automatic zero_inputs();
        req_cs = '0; m_busy = 1'b0; m_rdone = 1'b0; m_wdone = 1'b0;
        m_rsp_seq = '0; m_rsp_data = '0; m_rsp_addr = '0; m_rsp_mask = '0;
    endtask

    task automatic step(input logic [N-1:0] cs, input logic busy, input logic rd, input logic wd,
                        input logic [1:0] seq, input logic [31:0] d);
        @(posedge clk); #1;
        req_cs = cs; m_busy = busy; m_rdone = rd; m_wdone = wd;
        m_rsp_seq = seq; m_rsp_data = d; m_rsp_addr = d[21:0]; m_rsp_mask = d[3:0];
        @(negedge clk);
    endtask

    task automatic idle();
        step('0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; zero_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int order [3] = '{0, 2, 3};

    initial begin
        addr_tab = '{22'h000040, 22'h000100, 22'h001200, 22'h3ABCD4};
        mask_tab = '{4'hF, 4'h3, 4'hC, 4'h1};
        wdat_tab = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        for (int r = 0; r < N; r++) begin
            req_addr[r*22 +: 22]  = addr_tab[r];
            req_mask[r*4 +: 4]    = mask_tab[r];
            req_wdata[r*32 +: 32] = wdat_tab[r];
        end
        req_wr = '0;
        rst = 1'b1;
        zero_inputs();

        // Reset: outputs forced low even with requests and a response present.
        @(posedge clk); #1;
        req_cs = 4'b1111; m_rdone = 1'b1; m_rsp_seq = 2'd3; m_rsp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_m_cs", 32'(m_cs), 32'h0);
        chk("rst_ack", 32'(req_ack), 32'h0);
        chk("rst_orphan", 32'(orphan), 32'h0);
        chk("rst_rdone", 32'(rsp_rdone), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_m_addr", 32'(m_addr), 32'h0);
        do_reset();

        // Single read.
        push_ack(1, 2'd0, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        idle();
        push_evt(K_RD, 1, 32'hDEADBEEF);
        step('0, 1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF);
        idle();

        // Round-robin among 0, 2, 3 with each tag answered the following cycle.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_ack(order[k % 3], 2'(k % 2), 1'b0);
            if (k > 0) push_evt(K_RD, order[(k - 1) % 3], 32'hA000_0000 + k);
            step(4'b1101, 1'b0, (k > 0), 1'b0, 2'((k + 1) % 2), 32'hA000_0000 + k);
        end
        push_evt(K_RD, 3, 32'hA000_0006);
        step('0, 1'b0, 1'b1, 1'b0, 2'd1, 32'hA000_0006);
        idle();

        // Tag exhaustion, then reuse of a freed tag one cycle after its response.
        do_reset();
        push_ack(0, 2'd0, 1'b0);
        push_ack(1, 2'd1, 1'b0);
        push_ack(2, 2'd2, 1'b0);
        push_ack(3, 2'd3, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1101, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        chk("full_m_cs_a", 32'(m_cs), 32'h0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        chk("full_m_cs_b", 32'(m_cs), 32'h0);
        push_evt(K_RD, 2, 32'hC0DE_0002);
        step(4'b0001, 1'b0, 1'b1, 1'b0, 2'd2, 32'hC0DE_0002);
        chk("full_m_cs_c", 32'(m_cs), 32'h0);
        push_ack(0, 2'd2, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        push_evt(K_RD, 0, 32'hC0DE_0000);
        step('0, 1'b0, 1'b1, 1'b0, 2'd0, 32'hC0DE_0000);
        push_evt(K_RD, 1, 32'hC0DE_0001);
        step('0, 1'b0, 1'b1, 1'b0, 2'd1, 32'hC0DE_0001);
        push_evt(K_RD, 3, 32'hC0DE_0003);
        step('0, 1'b0, 1'b1, 1'b0, 2'd3, 32'hC0DE_0003);
        push_evt(K_RD, 0, 32'hC0DE_0012);
        step('0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hC0DE_0012);
        idle();

        // Busy stall, then out-of-order completion of a write and a read.
        do_reset();
        req_wr = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step(4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
            chk("busy_ack", 32'(req_ack), 32'h0);
            chk("busy_m_cs", 32'(m_cs), 32'h1);
        end
        chk("busy_m_addr", 32'(m_addr), 32'(addr_tab[1]));
        push_ack(1, 2'd0, 1'b1);
        step(4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        chk("wr_m_wdata", m_wdata, wdat_tab[1]);
        chk("wr_m_mask", 32'(m_mask), 32'(mask_tab[1]));
        push_ack(2, 2'd1, 1'b0);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        push_evt(K_RD, 2, 32'h0B0B_0001);
        step('0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0B0B_0001);
        push_evt(K_WD, 1, 32'h0B0B_0000);
        step('0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0B0B_0000);
        idle();
        req_wr = '0;

        // Orphan on an empty table, then reset with two tags outstanding.
        do_reset();
        push_evt(K_ORPH, -1, 32'h0000_5555);
        step('0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_5555);
        push_ack(0, 2'd0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        push_ack(1, 2'd1, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        idle();
        @(posedge clk); #1;
        rst = 1'b1; req_cs = 4'b0011; m_rdone = 1'b1; m_rsp_seq = 2'd0; m_rsp_data = 32'h1234;
        @(negedge clk);
        chk("mid_rst_m_cs", 32'(m_cs), 32'h0);
        chk("mid_rst_ack", 32'(req_ack), 32'h0);
        chk("mid_rst_rdone", 32'(rsp_rdone), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; zero_inputs();
        push_evt(K_ORPH, -1, 32'h0000_0A00);
        step('0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0A00);
        push_evt(K_ORPH, -1, 32'h0000_0A01);
        step('0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0A01);
        push_ack(0, 2'd0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        push_evt(K_RD, 0, 32'h0000_0B00);
        step('0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0B00);
        idle();

`ifdef RCN_MASTER_ARB_TIMEOUT_EN
        // Timeout after 16 cycles, reuse the next cycle, late response is an orphan.
        do_reset();
        push_ack(0, 2'd0, 1'b0);
        push_ack(1, 2'd1, 1'b0);
        push_ack(2, 2'd2, 1'b0);
        push_ack(3, 2'd3, 1'b0);
        push_evt(K_TMO, 0, 32'h0);
        push_ack(0, 2'd0, 1'b0);
        push_evt(K_TMO, 1, 32'h0);
        push_evt(K_TMO, 2, 32'h0);
        push_evt(K_TMO, 3, 32'h0);
        push_evt(K_ORPH, -1, 32'h0000_0066);
        push_evt(K_TMO, 0, 32'h0);
        step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1110, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        repeat (13) idle();
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        chk("tmo_full_m_cs", 32'(m_cs), 32'h0);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        idle();
        idle();
        step('0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0066);
        repeat (16) idle();
`endif

        repeat (2) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rcn_master_arb.md
# rcn_master_arb

Shares one `rcn_master` port among `NUM_REQ` local requesters. It arbitrates round-robin and allocates the four 2-bit `seq` tags as outstanding-transaction slots. It then routes each returning response to the requester that owns the tag. It sits between the requesters and the `cs/seq/busy/...` side of a single `rcn_master`.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1023: response timeout in cycles. Used only with `RCN_MASTER_ARB_TIMEOUT_EN`.

**Ports** (clock and reset first)
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_cs` in NUM_REQ: request valid, one bit per requester. Held until acked.
- `req_wr` in NUM_REQ: 1 = write.
- `req_mask` in 4*NUM_REQ: byte enables; requester i owns bits [4i+3:4i].
- `req_addr` in 22*NUM_REQ: byte address; bits [1:0] ignored.
- `req_wdata` in 32*NUM_REQ: write data.
- `req_ack` out NUM_REQ: one-cycle pulse; that requester's request was issued this cycle.
- `rsp_rdone` out NUM_REQ: one-cycle read-complete pulse to the tag owner.
- `rsp_wdone` out NUM_REQ: one-cycle write-complete pulse to the tag owner.
- `rsp_timeout` out NUM_REQ: one-cycle pulse; the owner's transaction was abandoned.
- `rsp_mask` out 4, `rsp_addr` out 22, `rsp_data` out 32: broadcast copies of the master response fields.
- `orphan` out 1: one-cycle pulse; a response arrived for a tag that is not allocated.
- `m_cs` out 1, `m_seq` out 2, `m_wr` out 1, `m_mask` out 4, `m_addr` out 22, `m_wdata` out 32: request side of `rcn_master`.
- `m_busy` in 1: from `rcn_master`.
- `m_rdone`, `m_wdone` in 1, `m_rsp_seq` in 2, `m_rsp_mask` in 4, `m_rsp_addr` in 22, `m_rsp_data` in 32: response side of `rcn_master`.

## Operation

**State**
- Tag table, 4 entries. Each entry holds `valid`, `owner` (clog2(NUM_REQ) bits) and `is_wr`.
- Round-robin pointer `rr_ptr`.

**Issue**
- `eligible` = `req_cs` AND (some tag is free). Free tags are computed from registered table state only.
- The grant `g` is the first set bit of `req_cs` at or after `rr_ptr`, searching cyclically.
- The allocated tag `t` is the lowest-numbered free tag.
- `m_cs` = eligible. `m_*` fields are muxed from requester `g`. `m_seq` = `t`.
- Accept = `m_cs && !m_busy`.
- On accept:
  - `req_ack[g]` pulses.
  - Next cycle: tag `t` becomes valid, with `owner` = `g` and `is_wr` = `req_wr[g]`.
  - `rr_ptr` becomes `(g+1) mod NUM_REQ`.
- While `m_busy` is high, the grant may change cycle to cycle; no ack is issued.
- Requester fields are not captured. The requester holds them until ack.

**Completion**
- On `m_rdone|m_wdone`, look up `m_rsp_seq`.
- If that tag is valid:
  - Pulse `rsp_rdone[owner]` or `rsp_wdone[owner]` in the same cycle (combinational).
  - Clear the tag at the next edge.
- If that tag is invalid: pulse `orphan`; the table is unchanged.
- Responses may complete out of order.
- Broadcast `rsp_*` fields are combinational copies of `m_rsp_*`.

**Boundaries**
- All 4 tags valid: `m_cs` = 0 and requests stall, even when `m_busy` = 0.
- Accept and completion in the same cycle: both take effect. The tag freed in that cycle is not reusable until the following cycle.
- Two requests only from one requester: that requester is still granted every eligible cycle. Back-to-back acks are allowed.
- `rst` asserted mid-transaction:
  - The table is cleared and `rr_ptr` becomes 0.
  - Later responses for the old tags report `orphan`.
  - All outputs are forced to 0 while `rst` is high.

## Timing

- Issue latency from `req_cs` rising to ack: 0 cycles when a tag is free and `m_busy` = 0.
- Completion latency from `m_rdone`/`m_wdone` to `rsp_*done`: 0 cycles.
- Tag reuse: the earliest reallocation of a tag is the cycle after its completion.
- Reset values:
  - `req_ack`, `rsp_rdone`, `rsp_wdone`, `rsp_timeout`, `orphan`, `m_cs` = 0.
  - Every tag invalid; `rr_ptr` = 0.

## Configuration

Controlled by the macro `RCN_MASTER_ARB_TIMEOUT_EN`.

**With the macro defined**
- Each tag has a 10+ bit age counter, sized to hold `TIMEOUT`.
- The counter resets to 0 on allocation and increments each cycle while the tag is valid.
- When the counter reaches `TIMEOUT`, the tag is freed and `rsp_timeout[owner]` pulses.
- If a response arrives in the same cycle as the timeout, the response wins.
- A later response for that tag reports `orphan`.

**Without the macro**
- No counters are built.
- `rsp_timeout` is tied to 0.
- Tags are held until a response arrives.

## Structure

- Shared package `rcn_pkg` holds:
  - the rcn bus field widths: ID 6, SEQ 2, MASK 4, ADDR 20 word bits, DATA 32;
  - `RCN_NUM_TAGS` = 4.
- Sub-module `rcn_rr_pick`: a parameterised rotating-priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and grant index.

## Test plan

1. **Single read.** Requester 1 reads 0x000100 with `m_busy` = 0 → `req_ack[1]` in the same cycle, `m_seq` = 0. A later `m_rdone` with seq 0 and data 0xDEADBEEF → `rsp_rdone[1]` and `rsp_data` = 0xDEADBEEF.
2. **Round-robin.** Requesters 0, 2 and 3 all request continuously, and responses return promptly → ack order is 0, 2, 3, 0, 2, 3.
3. **Tag exhaustion.** Five requests with no responses → 4 acks, tags 0..3; then `m_cs` = 0. A response on seq 2 → the fifth request is acked one cycle later, with `m_seq` = 2.
4. **Busy and out-of-order.** `m_busy` is held high for 5 cycles → no ack. Then responses return in order seq 1, then seq 0 → each done pulse goes to the correct owner.
5. **Orphan and reset.** A response on an unallocated seq 3 → `orphan` pulses and the table is unchanged. `rst` with 2 tags outstanding → after reset, those responses report `orphan`.
6. **Timeout** (`RCN_MASTER_ARB_TIMEOUT_EN`, `TIMEOUT` = 16). No response → `rsp_timeout[owner]` pulses 16 cycles after allocation and the tag is reusable the next cycle.
